// File: rtl/fpu_pkg.sv
// Shared FPU definitions: issue FSM states, floating-point constants and
// default tag width used by the multiplier issue path.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fmul_state_e;

    localparam logic [31:0] QNAN           = 32'h7FC0_0000;
    localparam int          FMUL_TAG_W_DEF = 5;

endpackage

// File: rtl/fmul_issue_fifo.sv
// Synchronous operand FIFO for the multiplier issue queue; the head entry is
// presented combinationally and only leaves on an explicit pop.
module fmul_issue_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64 + FMUL_TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign head   = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Entry storage, cleared on reset so the head reads as zero when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fmul_issue.sv
// Operand queue and issue controller in front of the FPU multiplier.
// Optional WAIT-state watchdog enabled by defining FMUL_ISSUE_TIMEOUT_EN.
module fmul_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = FMUL_TAG_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fmul_order,
    input  logic             fmul_accepted,
    input  logic             fmul_done,
    output logic [31:0]      fmul_rs1,
    output logic [31:0]      fmul_rs2,
    input  logic [31:0]      fmul_rd,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic             timeout_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 64 + TAG_W;

    logic [EW-1:0]    wdata_s;
    logic [EW-1:0]    head_s;
    logic [CW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             capture_s;
    logic             timeout_hit_s;
    fmul_state_e      state_r;
    fmul_state_e      state_nxt_s;
    logic [31:0]      res_data_r;
    logic [TAG_W-1:0] res_tag_r;

    assign wdata_s   = {in_rs1, in_rs2, in_tag};
    assign push_s    = in_valid & ~full_s;
    assign capture_s = (state_r == WAIT) & (fmul_done | timeout_hit_s);

    fmul_issue_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (capture_s),
        .wdata (wdata_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

`ifdef FMUL_ISSUE_TIMEOUT_EN
    logic [3:0] tmo_cnt_r;
    logic       timeout_err_r;

    // Fires in the TIMEOUT-th consecutive WAIT cycle without a done
    assign timeout_hit_s = ~fmul_done & (tmo_cnt_r == 4'(TIMEOUT - 1));
    assign timeout_err   = timeout_err_r;

    // WAIT-cycle watchdog counter, restarted on every accept
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= 4'd0;
        end else if ((state_r == REQ) && fmul_accepted) begin
            tmo_cnt_r <= 4'd0;
        end else if ((state_r == WAIT) && !fmul_done) begin
            tmo_cnt_r <= tmo_cnt_r + 4'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else if (capture_s && timeout_hit_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; stray accept/done outside their states are ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = empty_s       ? IDLE : REQ;
            REQ:     state_nxt_s = fmul_accepted ? WAIT : REQ;
            WAIT:    state_nxt_s = capture_s     ? HOLD : WAIT;
            HOLD:    state_nxt_s = res_ready     ? IDLE : HOLD;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        fmul_order = 1'b0;
        res_valid  = 1'b0;
        case (state_r)
            REQ:     fmul_order = 1'b1;
            HOLD:    res_valid  = 1'b1;
            default: begin
                fmul_order = 1'b0;
                res_valid  = 1'b0;
            end
        endcase
    end

    // Result capture; a watchdog expiry returns a quiet NaN for the head tag
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_r <= 32'h0000_0000;
            res_tag_r  <= '0;
        end else if (capture_s) begin
            res_data_r <= fmul_done ? fmul_rd : QNAN;
            res_tag_r  <= head_s[TAG_W-1:0];
        end else begin
            res_data_r <= res_data_r;
            res_tag_r  <= res_tag_r;
        end
    end

    assign in_ready = (count_s < CW'(DEPTH));
    assign busy     = ~empty_s | (state_r != IDLE);
    assign fmul_rs1 = head_s[EW-1 -: 32];
    assign fmul_rs2 = head_s[EW-33 -: 32];
    assign res_data = res_data_r;
    assign res_tag  = res_tag_r;

endmodule

// File: tb/tb_fmul_issue.sv
// Scoreboard bench for fmul_issue with a table-driven multiplier stub.
module tb_fmul_issue;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             fmul_order;
    logic             fmul_accepted;
    logic             fmul_done;
    logic [31:0]      fmul_rs1;
    logic [31:0]      fmul_rs2;
    logic [31:0]      fmul_rd;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             busy;
    logic             timeout_err;

    fmul_issue #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_tag        (in_tag),
        .fmul_order    (fmul_order),
        .fmul_accepted (fmul_accepted),
        .fmul_done     (fmul_done),
        .fmul_rs1      (fmul_rs1),
        .fmul_rs2      (fmul_rs2),
        .fmul_rd       (fmul_rd),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    // Hand-computed IEEE single products: va[i] * vb[i] = vp[i]
    logic [31:0] va [8] = '{32'h4000_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'hC000_0000,
                            32'h4080_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4120_0000};
    logic [31:0] vb [8] = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000,
                            32'h3E80_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4120_0000};
    logic [31:0] vp [8] = '{32'h40C0_0000, 32'h3F80_0000, 32'h4040_0000, 32'hBF80_0000,
                            32'h3F80_0000, 32'h4110_0000, 32'h3E80_0000, 32'h42C8_0000};

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t        sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    int          mul_cnt    = 0;
    int          done_delay = 3;
    logic [31:0] mul_res    = 32'h0;
    logic        acc_en     = 1'b1;
    logic        spur_en    = 1'b0;
    logic        never_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 8; i++) begin
            if (va[i] == a && vb[i] == b) return vp[i];
        end
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier stub: accept on order, done exactly done_delay cycles later
    initial begin
        fmul_accepted = 1'b0;
        fmul_done     = 1'b0;
        fmul_rd       = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            fmul_done     = 1'b0;
            fmul_accepted = 1'b0;
            if (rst) begin
                mul_cnt = 0;
            end else begin
                if (mul_cnt > 0) begin
                    mul_cnt--;
                    if (mul_cnt == 0 && !never_done) begin
                        fmul_done = 1'b1;
                        fmul_rd   = mul_res;
                    end
                end
                if (spur_en && fmul_order) begin
                    fmul_done = 1'b1;
                    fmul_rd   = 32'hBAD0_BAD0;
                end
                if (fmul_order && acc_en && mul_cnt == 0) begin
                    fmul_accepted = 1'b1;
                    mul_cnt       = done_delay;
                    mul_res       = lookup(fmul_rs1, fmul_rs2);
                end
            end
        end
    end

    // Monitor: compare every result handed to the consumer against the queue
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got data %h tag %0d, expected no result", res_data, res_tag);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_data", res_data, e.d);
                chk("res_tag", 32'(res_tag), 32'(e.t));
            end
        end
    end

    task automatic push(input int v, input logic [TAG_W-1:0] tag, input logic [31:0] expd, output int acc);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_rs1   = va[v];
        in_rs2   = vb[v];
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc;
        if (in_ready) begin
            sb_q.push_back('{expd, tag});
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL push_wait: got in_ready 0, expected 1 within 40 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!res_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        c = cyc;
        if (!res_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got res_valid 0, expected 1 within 60 cycles", name);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy || sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got busy %0b pending %0d, expected idle", busy, sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int a1;
        int c;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rs1    = 32'h0;
        in_rs2    = 32'h0;
        in_tag    = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_fmul_order", 32'(fmul_order), 32'd0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_fmul_rs1", fmul_rs1, 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;

        // Single request 2.0 * 3.0, six-cycle latency
        push(0, 5'd7, vp[0], a0);
        wait_valid("t1_valid", c);
        chk("t1_latency", 32'(c - a0), 32'd6);
        wait_idle();

        // Five back-to-back pushes into a depth-4 queue
        for (int i = 0; i < 4; i++) begin
            push(i + 1, 5'(i), vp[i + 1], a1);
            if (i == 0) a0 = a1;
        end
        in_valid = 1'b1;
        @(negedge clk);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        push(5, 5'd4, vp[5], a1);
        chk("t2_fifth_accept", 32'(a1 - a0), 32'd6);
        wait_idle();

        // Consumer stalls 10 cycles in HOLD while the queue fills
        res_ready = 1'b0;
        push(0, 5'd3, vp[0], a0);
        wait_valid("t3_valid", c);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i < 5);
            in_rs1   = va[i + 1];
            in_rs2   = vb[i + 1];
            in_tag   = 5'(16 + i);
            @(negedge clk);
            chk("t3_hold_valid", 32'(res_valid), 32'd1);
            chk("t3_hold_data", res_data, vp[0]);
            chk("t3_hold_tag", 32'(res_tag), 32'd3);
            chk("t3_no_order", 32'(fmul_order), 32'd0);
            if (i < 5) chk("t3_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            if (in_valid && in_ready) sb_q.push_back('{vp[i + 1], 5'(16 + i)});
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_idle();

        // Reset while in WAIT with three requests queued
        push(1, 5'd1, vp[1], a0);
        push(2, 5'd2, vp[2], a1);
        push(3, 5'd3, vp[3], a1);
        chk("t4_pre_busy", 32'(busy), 32'd1);
        chk("t4_pre_no_order", 32'(fmul_order), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        push(2, 5'd9, vp[2], a0);
        wait_valid("t4_valid", c);
        chk("t4_latency", 32'(c - a0), 32'd6);
        wait_idle();

`ifdef FMUL_ISSUE_TIMEOUT_EN
        // Multiplier never completes: watchdog returns a quiet NaN
        never_done = 1'b1;
        push(5, 5'd13, 32'h7FC0_0000, a0);
        wait_valid("t5_valid", c);
        chk("t5_latency", 32'(c - a0), 32'd18);
        chk("t5_timeout_err", 32'(timeout_err), 32'd1);
        @(posedge clk);
        #1;
        never_done = 1'b0;
        wait_idle();
        chk("t5_err_sticky", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_err_cleared", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
`else
        // Slow multiplier: WAIT holds well past the watchdog limit
        done_delay = 20;
        push(5, 5'd13, vp[5], a0);
        wait_valid("t5_valid", c);
        chk("t5_latency", 32'(c - a0), 32'd23);
        chk("t5_timeout_err", 32'(timeout_err), 32'd0);
        done_delay = 3;
        wait_idle();
`endif

        // Stray done pulses while the order is still pending are ignored
        acc_en  = 1'b0;
        spur_en = 1'b1;
        push(6, 5'd12, vp[6], a0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_result", 32'(res_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("t6_still_req", 32'(fmul_order), 32'd1);
        acc_en  = 1'b1;
        spur_en = 1'b0;
        a0      = cyc;
        wait_valid("t6_valid", c);
        chk("t6_latency", 32'(c - a0), 32'd4);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
